// File: rtl/sat_counter_gen_pkg.sv
// Shared types and helpers for the prescaled saturating/wrapping counter.
package sat_counter_gen_pkg;

  typedef enum logic {
    COUNTING  = 1'b0,
    SATURATED = 1'b1
  } sat_state_e;

  function automatic int unsigned clamp_val(input int unsigned val,
                                            input int unsigned lo,
                                            input int unsigned hi);
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..PRESCALE-1 counter; tick marks the terminal count.
module tick_prescaler #(
  parameter int PRESCALE = 10000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);

  always_comb begin
    cnt_d = at_last ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Gated by reset so PRESCALE=1 does not tick while held in reset.
  assign tick = rst & at_last;

endmodule

// File: rtl/sat_counter_gen.sv
// Prescaled up/down counter with saturate or wrap at programmable bounds.
// Define SAT_COUNTER_GEN_STICKY_EN to compile in the sticky sat state machine.
module sat_counter_gen
  import sat_counter_gen_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 255,
  parameter int MIN_COUNT = 0,
  parameter int PRESCALE  = 10000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             wrap,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             tick,
  output logic             sat
);

  if (!(WIDTH >= 1 && WIDTH <= 32 && MIN_COUNT >= 0 && MIN_COUNT < MAX_COUNT &&
        (MAX_COUNT >> WIDTH) == 0 && PRESCALE >= 1)) begin : g_bad_params
    $error("sat_counter_gen: illegal WIDTH/MIN_COUNT/MAX_COUNT/PRESCALE combination");
  end

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_COUNT);

  // NOTE: reset asserts asynchronously through both flops but releases only after two clk edges.
  logic rst_meta_q, rst_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {rst_sync_q, rst_meta_q} <= 2'b00;
    else      {rst_sync_q, rst_meta_q} <= {rst_meta_q, 1'b1};
  end

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst_sync_q),
    .tick (tick)
  );

  logic [WIDTH-1:0] count_q, count_d;
  logic             step;

  assign step   = tick & en & ~load;
  assign at_max = (count_q == MAX_C);
  assign at_min = (count_q == MIN_C);
  assign count  = count_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = WIDTH'(clamp_val(32'(load_val), MIN_COUNT, MAX_COUNT));
    end else if (step) begin
      if (up) begin
        if (!at_max)   count_d = count_q + 1'b1;
        else if (wrap) count_d = MIN_C;
      end else begin
        if (!at_min)   count_d = count_q - 1'b1;
        else if (wrap) count_d = MAX_C;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) count_q <= MIN_C;
    else             count_q <= count_d;
  end

`ifdef SAT_COUNTER_GEN_STICKY_EN
  sat_state_e state_q, state_d;
  logic       blocked;

  // A wrap is never "blocked", so only saturating steps at a bound set the flag.
  assign blocked = step & ~wrap & (up ? at_max : at_min);

  always_comb begin
    state_d = state_q;
    case (state_q)
      COUNTING:  if (blocked) state_d = SATURATED;
      SATURATED: if (load)    state_d = COUNTING;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) state_q <= COUNTING;
    else             state_q <= state_d;
  end

  assign sat = (state_q == SATURATED);
`else
  assign sat = 1'b0;
`endif

endmodule

// File: tb/tb_sat_counter_gen.sv
// Bench for sat_counter_gen: two instances (PRESCALE=4 over 0..100, PRESCALE=1 over 10..200).
module tb_sat_counter_gen;

  localparam int P = 4;
`ifdef SAT_COUNTER_GEN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, wrap, load;
  logic [7:0] load_val, count;
  logic       at_max, at_min, tick, sat;
  logic       en2, up2, wrap2, load2;
  logic [7:0] load_val2, count2;
  logic       at_max2, at_min2, tick2, sat2;

  always #5 clk = ~clk;

  sat_counter_gen #(.WIDTH(8), .MAX_COUNT(100), .MIN_COUNT(0), .PRESCALE(P)) u_dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .wrap(wrap), .load(load),
    .load_val(load_val), .count(count), .at_max(at_max), .at_min(at_min),
    .tick(tick), .sat(sat)
  );

  sat_counter_gen #(.WIDTH(8), .MAX_COUNT(200), .MIN_COUNT(10), .PRESCALE(1)) u_dut2 (
    .clk(clk), .rst(rst), .en(en2), .up(up2), .wrap(wrap2), .load(load2),
    .load_val(load_val2), .count(count2), .at_max(at_max2), .at_min(at_min2),
    .tick(tick2), .sat(sat2)
  );

  int checks = 0;
  int errors = 0;
  int m_cnt, m_cnt2, phase;
  bit m_sat, m_sat2;

  typedef struct {
    logic [7:0] lv;
    int         exp1;
    int         exp2;
  } load_vec_t;
  load_vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the counting rules, on plain integers.
  function automatic int next_count(input int c, input bit ld, input int lv, input bit t,
                                    input bit e, input bit u, input bit w,
                                    input int lo, input int hi, inout bit s);
    if (ld) begin
      s = 1'b0;
      return (lv < lo) ? lo : (lv > hi) ? hi : lv;
    end
    if (!(t && e)) return c;
    if (u) begin
      if (c < hi) return c + 1;
      if (w) return lo;
    end else begin
      if (c > lo) return c - 1;
      if (w) return hi;
    end
    if (STICKY) s = 1'b1;
    return c;
  endfunction

  task automatic cycle();
    bit m_tick;
    m_tick = (phase == P - 1);
    check("tick", 32'(tick), 32'(m_tick));
    check("tick2", 32'(tick2), 1);
    @(posedge clk);
    m_cnt  = next_count(m_cnt, load, int'(load_val), m_tick, en, up, wrap, 0, 100, m_sat);
    m_cnt2 = next_count(m_cnt2, load2, int'(load_val2), 1'b1, en2, up2, wrap2, 10, 200, m_sat2);
    phase  = (phase + 1) % P;
    @(negedge clk);
    check("count", 32'(count), m_cnt);
    check("at_max", 32'(at_max), 32'(m_cnt == 100));
    check("at_min", 32'(at_min), 32'(m_cnt == 0));
    check("sat", 32'(sat), 32'(m_sat));
    check("count2", 32'(count2), m_cnt2);
    check("at_max2", 32'(at_max2), 32'(m_cnt2 == 200));
    check("at_min2", 32'(at_min2), 32'(m_cnt2 == 10));
    check("sat2", 32'(sat2), 32'(m_sat2));
  endtask

  task automatic run_ticks(input int n);
    int k = 0;
    while (k < n) begin
      if (phase == P - 1) k++;
      cycle();
    end
  endtask

  // After reset release, wait (bounded) for the first tick and lock the model phase to it.
  task automatic align();
    bit found = 1'b0;
    for (int i = 0; i < P + 6; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("first_tick_seen", 32'(found), 1);
    check("count_at_first_tick", 32'(count), 0);
    phase = P - 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'd200, 100, 200};
    vecs[1] = '{8'd37,  37,  37};
    vecs[2] = '{8'd101, 100, 101};
    vecs[3] = '{8'd255, 100, 200};
    vecs[4] = '{8'd5,   5,   10};
    vecs[5] = '{8'd0,   0,   10};

    rst = 1'b0;
    {en, up, wrap, load, load_val} = '0;
    {en2, up2, wrap2, load2, load_val2} = '0;
    m_cnt = 0; m_sat = 1'b0; m_cnt2 = 10; m_sat2 = 1'b0; phase = 0;

    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 0);
    check("rst_at_min", 32'(at_min), 1);
    check("rst_at_max", 32'(at_max), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_sat", 32'(sat), 0);
    check("rst_count2", 32'(count2), 10);
    check("rst_tick2", 32'(tick2), 0);

    #2 rst = 1'b1;
    en = 1'b1; up = 1'b1; wrap = 1'b0;
    align();

    // Count up to the top bound, then one blocked step.
    run_ticks(100);
    check("reach_max_count", 32'(count), 100);
    check("reach_max_at_max", 32'(at_max), 1);
    check("reach_max_sat", 32'(sat), 0);
    run_ticks(1);
    check("blocked_up_count", 32'(count), 100);
    check("blocked_up_sat", 32'(sat), 32'(STICKY));

    // Wrap from top to bottom leaves sat untouched.
    wrap = 1'b1;
    run_ticks(1);
    check("wrap_count", 32'(count), 0);
    check("wrap_at_min", 32'(at_min), 1);
    check("wrap_sat", 32'(sat), 32'(STICKY));

    // Clear sat by load, block at bottom, then step up while saturated.
    wrap = 1'b0; en = 1'b0;
    load = 1'b1; load_val = 8'd0;
    cycle();
    load = 1'b0;
    check("load_clears_sat", 32'(sat), 0);
    en = 1'b1; up = 1'b0;
    run_ticks(1);
    check("blocked_down_count", 32'(count), 0);
    check("blocked_down_sat", 32'(sat), 32'(STICKY));
    up = 1'b1;
    run_ticks(1);
    check("up_while_sat_count", 32'(count), 1);
    check("up_while_sat_sat", 32'(sat), 32'(STICKY));

    // Table of clamped loads, each coinciding with a tick and an enabled step.
    foreach (vecs[i]) begin
      en = 1'b0; en2 = 1'b0;
      while (phase != P - 1) cycle();
      en = 1'b1; up = 1'b1; en2 = 1'b1; up2 = 1'b1;
      load = 1'b1; load_val = vecs[i].lv;
      load2 = 1'b1; load_val2 = vecs[i].lv;
      cycle();
      load = 1'b0; load2 = 1'b0;
      check("table_load_count", 32'(count), vecs[i].exp1);
      check("table_load_count2", 32'(count2), vecs[i].exp2);
      check("table_load_sat", 32'(sat), 0);
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      en    = 1'($urandom_range(0, 3) != 0);
      up    = 1'($urandom_range(0, 1));
      wrap  = 1'($urandom_range(0, 2) == 0);
      load  = 1'($urandom_range(0, 31) == 0);
      load_val = 8'($urandom);
      en2   = 1'($urandom_range(0, 1));
      up2   = 1'($urandom_range(0, 1));
      wrap2 = 1'($urandom_range(0, 2) == 0);
      load2 = 1'($urandom_range(0, 31) == 0);
      load_val2 = 8'($urandom);
      cycle();
    end
    {en, load, en2, load2} = '0;

    // PRESCALE=1 instance with en toggling every cycle.
    load2 = 1'b1; load_val2 = 8'd50;
    cycle();
    load2 = 1'b0; up2 = 1'b1; wrap2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      en2 = 1'(i % 2);
      cycle();
      check("toggle_en_sat2", 32'(sat2), 0);
    end
    en2 = 1'b0;
    check("toggle_en_count2", 32'(count2), 60);

    // Asynchronous reset mid-count with a load pending.
    load = 1'b1; load_val = 8'd55;
    cycle();
    load = 1'b0;
    cycle();
    check("pre_reset_count", 32'(count), 55);
    load = 1'b1; load_val = 8'd77;
    #2 rst = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 0);
    check("async_rst_tick", 32'(tick), 0);
    check("async_rst_sat", 32'(sat), 0);
    check("async_rst_at_min", 32'(at_min), 1);
    check("async_rst_at_max", 32'(at_max), 0);
    check("async_rst_count2", 32'(count2), 10);
    @(posedge clk);
    @(negedge clk);
    check("rst_discards_load", 32'(count), 0);
    load = 1'b0;
    m_cnt = 0; m_sat = 1'b0; m_cnt2 = 10; m_sat2 = 1'b0;

    #2 rst = 1'b1;
    en = 1'b1; up = 1'b1; wrap = 1'b0;
    align();
    run_ticks(3);
    check("post_reset_count", 32'(count), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
